ram1r1w_be_init: RTL
====================

# ram1r1w_be_init

Parametrised 1-read/1-write synchronous RAM with per-byte write enables, read-enable with valid qualifier, and a self-clearing init sequencer that zeroes every entry after reset. It generalises the fixed-width byte-enabled data array to any width that is a multiple of 8 and any power-of-two depth. It is the common storage primitive for L1D data, store-buffer and predictor tables that need a known-zero state without an FPGA initial block.

## Interface
- WIDTH, 128, data width in bits; must be a multiple of 8
- LG_DEPTH, 6, log2 of entry count; DEPTH = 1<<LG_DEPTH
- NUM_BYTES (localparam), WIDTH/8
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high reset
- rd_en  in  1  read request
- rd_addr  in  LG_DEPTH  read index
- wr_en  in  1  write request
- wr_addr  in  LG_DEPTH  write index
- wr_data  in  WIDTH  write data; byte b = wr_data[8b+7:8b]
- wr_byte_en  in  NUM_BYTES  per-byte write mask
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  rd_data updated by an accepted read this cycle
- init_busy  out  1  clear sequence in progress; requests ignored

## Operation
- States: CLEAR, READY. reset forces CLEAR, clear counter = 0.
- CLEAR: each cycle with reset low writes all-zero to entry[counter], counter += 1. Write of entry DEPTH-1 transitions to READY. Counter width LG_DEPTH; no wrap is observed since transition occurs on the last entry.
- In CLEAR, rd_en and wr_en are ignored: no array write from ports, rd_valid stays 0, rd_data holds.
- READY: wr_en writes byte b of entry[wr_addr] iff wr_byte_en[b]; other bytes unchanged. wr_en with wr_byte_en = 0 is a no-op.
- READY: rd_en reads entry[rd_addr] into rd_data; rd_valid = 1 next cycle. rd_en = 0: rd_data holds its previous value, rd_valid = 0.
- Same-address read and write in one cycle: behaviour per Configuration. Different addresses: fully independent.
- Reset mid-CLEAR or mid-READY: sequence restarts from entry 0; contents of already-written entries are re-zeroed.

## Timing
- Reset values (cycle after reset sampled high): rd_data = 0, rd_valid = 0, init_busy = 1, state CLEAR.
- init_busy stays 1 for exactly DEPTH cycles after the first cycle reset is sampled low; falls on the edge that clears entry DEPTH-1.
- First accepted request: the cycle in which init_busy is observed 0.
- Read latency 1: request at edge N, rd_data/rd_valid valid after edge N+1.
- Write visible to a read issued the cycle after the write (read at edge N+1 returns data written at edge N).
- Throughput: one read and one write per cycle, no stalls in READY.

## Configuration
- RAM1R1W_BYPASS_EN defined: same-cycle rd_en & wr_en & rd_addr == wr_addr returns merged data: byte b = wr_data byte b if wr_byte_en[b], else prior array byte. rd_valid as normal.
- RAM1R1W_BYPASS_EN undefined: same-address collision returns prior array contents (read-before-write); the write still commits.
- Neither mode alters write results, latency, or init behaviour.

## Test plan
- Init: WIDTH=32, LG_DEPTH=3, preload via writes, pulse reset 1 cycle -> init_busy = 1 for exactly 8 cycles; then reads of all 8 entries return 0x00000000 with rd_valid = 1.
- Byte write: write entry 5 = 0xAABBCCDD mask 4'b1111, then 0x11223344 mask 4'b0101 -> read entry 5 returns 0xAA22CC44.
- Collision: entry 2 = 0x01020304; same cycle read 2 and write 0xFFFFFFFF mask 4'b0011 -> RAM1R1W_BYPASS_EN: rd_data 0x0102FFFF; without: 0x01020304; next read 2 returns 0x0102FFFF in both.
- Ignore during CLEAR: wr_en to entry 1 = 0xDEADBEEF and rd_en while init_busy = 1 -> rd_valid stays 0; after READY entry 1 reads 0.
- Reset mid-clear: assert reset at cycle 4 of CLEAR -> init_busy stays 1 for 8 further cycles after reset deasserts; all entries read 0.
- Hold: read entry 5 (0xAA22CC44), then rd_en = 0 for 3 cycles -> rd_data stays 0xAA22CC44, rd_valid = 0.

Source files
------------

// File: rtl/ram1r1w_be_init.sv
// 1-read/1-write byte-enabled RAM that zeroes every entry after reset before accepting requests.
// Optional same-address write-to-read bypass: define RAM1R1W_BYPASS_EN.
module ram1r1w_be_init #(
  parameter int WIDTH    = 128,
  parameter int LG_DEPTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [LG_DEPTH-1:0]   rd_addr,
  input  logic                  wr_en,
  input  logic [LG_DEPTH-1:0]   wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [WIDTH/8-1:0]    wr_byte_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  init_busy
);

  localparam int NUM_BYTES = WIDTH / 8;
  localparam int DEPTH     = 1 << LG_DEPTH;

  typedef enum logic {CLEAR, READY} state_e;

  state_e                        state_q, state_d;
  logic [LG_DEPTH-1:0]           clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0]              rd_data_q, rd_data_d;
  logic                          rd_valid_q, rd_valid_d;

  logic                          rd_fire;
  logic [NUM_BYTES-1:0]          lane_we;
  logic [LG_DEPTH-1:0]           lane_waddr;
  logic [NUM_BYTES-1:0][7:0]     lane_wdata;
  logic [NUM_BYTES-1:0][7:0]     lane_rdata;
  logic [NUM_BYTES-1:0][7:0]     rd_merged;

  // Clear sequencer: one entry per cycle, leaves CLEAR on the last entry.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + LG_DEPTH'(1);
      if (clr_cnt_q == '1) state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign init_busy = (state_q == CLEAR);

  // Write port is shared between the sequencer (all bytes, zero data) and the user.
  always_comb begin
    lane_we    = '0;
    lane_waddr = wr_addr;
    lane_wdata = wr_data;
    if (!reset) begin
      if (state_q == CLEAR) begin
        lane_we    = '1;
        lane_waddr = clr_cnt_q;
        lane_wdata = '0;
      end else if (wr_en) begin
        lane_we = wr_byte_en;
      end
    end
  end

  genvar b;
  generate
    for (b = 0; b < NUM_BYTES; b++) begin : g_lane
      logic [7:0] ram [DEPTH];

      always_ff @(posedge clk) begin
        if (lane_we[b]) ram[lane_waddr] <= lane_wdata[b];
      end

      assign lane_rdata[b] = ram[rd_addr];

`ifdef RAM1R1W_BYPASS_EN
      // Forward the byte being written this cycle to a colliding read.
      assign rd_merged[b] = (lane_we[b] && (lane_waddr == rd_addr)) ? lane_wdata[b]
                                                                    : lane_rdata[b];
`else
      assign rd_merged[b] = lane_rdata[b];
`endif
    end
  endgenerate

  assign rd_fire = !reset && (state_q == READY) && rd_en;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_fire;
    if (rd_fire) rd_data_d = rd_merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule
